// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared GPIO constants: pin width, interrupt encodings, priming
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef GPIO_DATA_WIDTH
`define GPIO_DATA_WIDTH 16
`endif

package gpio_pkg;

  localparam int GPIO_DATA_WIDTH = `GPIO_DATA_WIDTH;

  typedef enum logic {
    INT_TYPE_EDGE  = 1'b0,
    INT_TYPE_LEVEL = 1'b1
  } int_type_e;

  // Same bit means rising/falling in edge mode and low/high in level mode.
  typedef enum logic {
    INT_POL_RISE_LOW  = 1'b0,
    INT_POL_FALL_HIGH = 1'b1
  } int_pol_e;

  localparam logic [1:0] PRIMED_DELAY = 2'd3;

endpackage

`default_nettype wire

// File: rtl/gpio_sync2.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync2
// Description : Parameterized-width two-flop synchronizer, async high reset
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_capture
// Description : GPIO input synchronizer with per-pin edge/level interrupts
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH = GPIO_DATA_WIDTH
) (
  input  logic                  pclk,
  input  logic                  p_reset,
  input  logic [DATA_WIDTH-1:0] gpio_pin_in,
  input  logic [DATA_WIDTH-1:0] n_gpio_pin_oe,
  input  logic [DATA_WIDTH-1:0] int_en,
  input  logic [DATA_WIDTH-1:0] int_type,
  input  logic [DATA_WIDTH-1:0] int_pol,
  input  logic [DATA_WIDTH-1:0] int_both,
  input  logic [DATA_WIDTH-1:0] int_clr,
  output logic [DATA_WIDTH-1:0] pin_value,
  output logic [DATA_WIDTH-1:0] int_status,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DATA_WIDTH-1:0] status_d;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;
  logic [DATA_WIDTH-1:0] evt;
  logic [DATA_WIDTH-1:0] set_cond;
  logic [1:0]            prime_cnt_q;
  logic [1:0]            prime_cnt_d;
  logic                  primed;

  gpio_sync2 #(
    .WIDTH (DATA_WIDTH)
  ) u_sync (
    .clk_i (pclk),
    .rst_i (p_reset),
    .d_i   (gpio_pin_in),
    .q_o   (pin_value)
  );

  assign rise = pin_value & ~prev_q;
  assign fall = ~pin_value & prev_q;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    logic edge_evt;
    logic level_evt;
    assign edge_evt  = (rise[i] & (int_pol[i] == INT_POL_RISE_LOW))
                     | (fall[i] & (int_pol[i] == INT_POL_FALL_HIGH))
                     | ((rise[i] | fall[i]) & int_both[i]);
    assign level_evt = (pin_value[i] == int_pol[i]);
    assign evt[i]    = (int_type[i] == INT_TYPE_LEVEL) ? level_evt : edge_evt;
  end

  // Until both sync stages and prev hold post-reset samples, events are bogus.
  assign primed   = (prime_cnt_q == PRIMED_DELAY);
  assign set_cond = evt & int_en & n_gpio_pin_oe & {DATA_WIDTH{primed}};

  always_comb begin
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 2'd1;
    status_d    = set_cond | (status_q & ~int_clr);
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      prev_q      <= '0;
      status_q    <= '0;
      prime_cnt_q <= '0;
    end else begin
      prev_q      <= pin_value;
      status_q    <= status_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign int_status = status_q;
  assign irq        = |status_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_in_capture
// Description : Self-checking bench for gpio_in_capture with a delay-line model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_in_capture;

  localparam int W = 16;

  logic         pclk;
  logic         p_reset;
  logic [W-1:0] gpio_pin_in;
  logic [W-1:0] n_gpio_pin_oe;
  logic [W-1:0] int_en;
  logic [W-1:0] int_type;
  logic [W-1:0] int_pol;
  logic [W-1:0] int_both;
  logic [W-1:0] int_clr;
  logic [W-1:0] pin_value;
  logic [W-1:0] int_status;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_in_capture #(.DATA_WIDTH(W)) dut (
    .pclk          (pclk),
    .p_reset       (p_reset),
    .gpio_pin_in   (gpio_pin_in),
    .n_gpio_pin_oe (n_gpio_pin_oe),
    .int_en        (int_en),
    .int_type      (int_type),
    .int_pol       (int_pol),
    .int_both      (int_both),
    .int_clr       (int_clr),
    .pin_value     (pin_value),
    .int_status    (int_status),
    .irq           (irq)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Reference model: a history of pad samples since reset (newest first).
  // Before edge k, pin_value is the sample from edge k-2 and prev from k-3.
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_status;
  logic [W-1:0] exp_pv;
  int           edges_since_rst;

  always @(posedge pclk or posedge p_reset) begin
    logic [W-1:0] pv, pr, ev, setb;
    if (p_reset) begin
      hist.delete();
      exp_status      = '0;
      exp_pv          = '0;
      edges_since_rst = 0;
    end else begin
      pv = (hist.size() >= 2) ? hist[1] : '0;
      pr = (hist.size() >= 3) ? hist[2] : '0;
      for (int i = 0; i < W; i++) begin
        if (int_type[i])
          ev[i] = (pv[i] == int_pol[i]);
        else
          ev[i] = (int_both[i] && (pv[i] != pr[i]))
               || (int_pol[i] ? (pr[i] && !pv[i]) : (pv[i] && !pr[i]));
      end
      setb       = ev & int_en & n_gpio_pin_oe & {W{edges_since_rst >= 3}};
      exp_status = setb | (exp_status & ~int_clr);
      hist.push_front(gpio_pin_in);
      if (hist.size() > 3) void'(hist.pop_back());
      if (edges_since_rst < 3) edges_since_rst++;
      exp_pv = (hist.size() >= 2) ? hist[1] : '0;
    end
  end

  task automatic set_cfg(input logic [W-1:0] en, typ, pol, both, oe);
    int_en = en; int_type = typ; int_pol = pol; int_both = both; n_gpio_pin_oe = oe;
  endtask

  task automatic clear_all();
    @(negedge pclk);
    int_en  = '0;
    int_clr = '1;
    @(negedge pclk);
    int_clr = '0;
  endtask

  task automatic test_reset();
    p_reset     = 1'b1;
    gpio_pin_in = '1;
    int_clr     = '0;
    set_cfg('1, '0, '0, '0, '1);
    repeat (2) @(negedge pclk);
    n_checks++;
    if (pin_value !== '0 || int_status !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pin_value=%h int_status=%h irq=%b, required 0/0/0",
               pin_value, int_status, irq);
    end
    p_reset     = 1'b0;
    gpio_pin_in = '0;
    set_cfg('0, '0, '0, '0, '1);
    repeat (5) @(negedge pclk);
  endtask

  task automatic test_rising_edge();
    set_cfg(16'h0001, '0, '0, '0, '1);
    @(negedge pclk);
    gpio_pin_in[0] = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (pin_value[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_pv_edge1: pin_value[0]=%b, required 0", pin_value[0]);
    end
    @(negedge pclk);
    n_checks++;
    if (pin_value[0] !== 1'b1 || int_status[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_pv_edge2: pin_value[0]=%b int_status[0]=%b, required 1/0",
               pin_value[0], int_status[0]);
    end
    @(negedge pclk);
    n_checks++;
    if (int_status !== 16'h0001 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_status: int_status=%h irq=%b, required 0001/1", int_status, irq);
    end
    int_clr = 16'h0001;
    @(negedge pclk);
    int_clr = '0;
    n_checks++;
    if (int_status !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_clear: int_status=%h irq=%b, required 0000/0", int_status, irq);
    end
  endtask

  task automatic test_both_clear();
    set_cfg(16'h0008, '0, '0, 16'h0008, '1);
    @(negedge pclk);
    gpio_pin_in[3] = 1'b1;
    repeat (4) @(negedge pclk);
    n_checks++;
    if (int_status !== 16'h0008) begin
      n_fail++;
      $display("FAIL both_rise: int_status=%h, required 0008", int_status);
    end
    int_clr = 16'h0008;
    @(negedge pclk);
    int_clr = '0;
    n_checks++;
    if (int_status !== '0) begin
      n_fail++;
      $display("FAIL both_clear: int_status=%h, required 0000", int_status);
    end
    gpio_pin_in[3] = 1'b0;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (int_status !== '0) begin
      n_fail++;
      $display("FAIL both_fall_early: int_status=%h, required 0000", int_status);
    end
    @(negedge pclk);
    n_checks++;
    if (int_status !== 16'h0008 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL both_fall: int_status=%h irq=%b, required 0008/1", int_status, irq);
    end
    clear_all();
  endtask

  task automatic test_level_persist();
    set_cfg(16'h0020, 16'h0020, 16'h0020, '0, '1);
    @(negedge pclk);
    gpio_pin_in[5] = 1'b1;
    repeat (4) @(negedge pclk);
    int_clr = 16'h0020;
    @(negedge pclk);
    int_clr = '0;
    n_checks++;
    if (int_status !== 16'h0020 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL level_persist: int_status=%h irq=%b, required 0020/1", int_status, irq);
    end
    gpio_pin_in[5] = 1'b0;
    repeat (3) @(negedge pclk);
    int_clr = 16'h0020;
    @(negedge pclk);
    int_clr = '0;
    n_checks++;
    if (int_status !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL level_release: int_status=%h irq=%b, required 0000/0", int_status, irq);
    end
    clear_all();
  endtask

  task automatic test_mask();
    set_cfg(16'h0080, '0, '0, 16'h0080, 16'hFF7F);
    for (int t = 0; t < 255; t++) begin
      @(negedge pclk);
      n_checks++;
      if (pin_value[7] !== exp_pv[7] || int_status[7] !== 1'b0) begin
        n_fail++;
        $display("FAIL mask_track[%0d]: pin_value[7]=%b int_status[7]=%b, required %b/0",
                 t, pin_value[7], int_status[7], exp_pv[7]);
      end
      gpio_pin_in[7] = ~gpio_pin_in[7];
    end
    repeat (4) @(negedge pclk);
    n_checks++;
    if (pin_value[7] !== 1'b1 || int_status !== '0) begin
      n_fail++;
      $display("FAIL mask_settle: pin_value[7]=%b int_status=%h, required 1/0000",
               pin_value[7], int_status);
    end
    n_gpio_pin_oe = '1;
    gpio_pin_in[7] = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if (int_status !== 16'h0080) begin
      n_fail++;
      $display("FAIL mask_unmasked: int_status=%h, required 0080", int_status);
    end
    clear_all();
  endtask

  task automatic test_set_clear_same();
    set_cfg(16'h0001, '0, '0, '0, '1);
    gpio_pin_in[0] = 1'b0;
    repeat (4) @(negedge pclk);
    n_checks++;
    if (int_status !== '0) begin
      n_fail++;
      $display("FAIL simul_pre: int_status=%h, required 0000", int_status);
    end
    gpio_pin_in[0] = 1'b1;
    repeat (2) @(negedge pclk);
    int_clr = 16'h0001;
    @(negedge pclk);
    int_clr = '0;
    n_checks++;
    if (int_status !== 16'h0001) begin
      n_fail++;
      $display("FAIL simul_set_wins: int_status=%h, required 0001", int_status);
    end
    clear_all();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge pclk);
      n_checks++;
      if (pin_value !== exp_pv || int_status !== exp_status || irq !== (|exp_status)) begin
        n_fail++;
        $display("FAIL random[%0d]: pv=%h st=%h irq=%b, required pv=%h st=%h irq=%b",
                 c, pin_value, int_status, irq, exp_pv, exp_status, |exp_status);
      end
      if (c % 20 == 0)
        set_cfg(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom) | 16'($urandom));
      gpio_pin_in = gpio_pin_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      int_clr     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '0;
    end
    int_clr = '0;
  endtask

  task automatic test_reset_priming();
    set_cfg('1, '0, '0, '0, '1);
    gpio_pin_in = '1;
    repeat (4) @(negedge pclk);
    @(posedge pclk);
    #2 p_reset = 1'b1;
    #1;
    n_checks++;
    if (pin_value !== '0 || int_status !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pin_value=%h int_status=%h irq=%b, required 0/0/0",
               pin_value, int_status, irq);
    end
    @(negedge pclk);
    p_reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge pclk);
      n_checks++;
      if (int_status !== '0 || pin_value !== exp_pv) begin
        n_fail++;
        $display("FAIL prime[%0d]: int_status=%h pin_value=%h, required 0000/%h",
                 c, int_status, pin_value, exp_pv);
      end
    end
    n_checks++;
    if (pin_value !== 16'hFFFF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL prime_end: pin_value=%h irq=%b, required FFFF/0", pin_value, irq);
    end
  endtask

  initial begin
    test_reset();
    test_rising_edge();
    test_both_clear();
    test_level_persist();
    test_mask();
    test_set_clear_same();
    test_random();
    test_reset_priming();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
